// File: rtl/enc_pkg.sv
// Shared helpers for the event encoder: index-width calculation and a
// "more than one bit set" test used to flag that other events were pending
// when one was selected.
package enc_pkg;

  // Widest request vector the multi-bit helper accepts; narrower vectors are
  // zero-extended by the caller.
  localparam int MAX_W = 256;

  // Ceiling log2, usable in constant expressions. Returns 1 for v <= 2 so an
  // index port is never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // True when popcount(v) > 1. Clearing the lowest set bit leaves something
  // behind exactly when a second bit was set.
  function automatic logic more_than_one(input logic [MAX_W-1:0] v);
    return |(v & (v - MAX_W'(1)));
  endfunction

endpackage

// File: rtl/event_encoder_prio_pick.sv
// Combinational find-first-set over N request bits. The search starts at
// base_i and walks upward, wrapping at N (not at 2^IDX_W), so the same block
// serves both fixed priority (base tied to 0) and rotating priority.
module prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] base_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan N positions starting at base_i; the first set bit wins.
  always_comb begin
    int pos;
    any_o = 1'b0;
    idx_o = '0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(base_i) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!any_o && req_i[pos]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Stateful N-to-log2(N) event encoder.
//
// Request pulses on req_i are captured into a sticky pending register (one
// slot per line) and drained one at a time as binary indices on a
// valid/ready output stream. Pending bits that are hit again while still
// pending set the sticky ovf_o flag.
//
// Build option: define EVENT_ENCODER_RR_EN for rotating priority (search
// starts at rr_ptr, which moves past each delivered index). Without it the
// lowest pending index always wins. The port list is the same either way.
//
// Handshake: out_idx_o/out_multi_o are valid while out_valid_o is high; an
// event transfers on a rising clk edge where out_valid_o && out_ready_i.
// Once raised, out_valid_o, out_idx_o and out_multi_o stay unchanged until
// that transfer happens; out_valid_o never depends combinationally on
// out_ready_i.
module event_encoder
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_multi_o,
  input  logic             ovf_clr_i,
  output logic             ovf_o,
  output logic             busy_o
);

  logic [N-1:0]     pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_multi_q, out_multi_d;
  logic             ovf_q, ovf_d;

  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] search_base;
  logic             load;
  logic [N-1:0]     sel_mask;

`ifdef EVENT_ENCODER_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Rotating priority: search begins at the line after the last delivery.
  assign search_base = rr_ptr_q;
`else
  // Fixed priority: search always begins at line 0.
  assign search_base = '0;
`endif

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (pending_q),
    .base_i (search_base),
    .any_o  (sel_any),
    .idx_o  (sel_idx)
  );

  // A new event enters the output register when something is pending and
  // the register is empty or being emptied this same cycle.
  assign load     = sel_any && (!out_valid_q || out_ready_i);
  assign sel_mask = load ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;

  // Next-state logic for pending, output register and overflow flag.
  always_comb begin
    pending_d   = (pending_q & ~sel_mask) | req_i;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;
    ovf_d       = ovf_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel_idx;
      out_multi_d = more_than_one(MAX_W'(pending_q));
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // A request landing on a bit that stays pending is lost; a request on
    // the bit being loaded right now is a fresh event and is kept.
    if (|(req_i & pending_q & ~sel_mask)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

`ifdef EVENT_ENCODER_RR_EN
  // Advance the rotating pointer past each loaded index, wrapping at N.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      rr_ptr_d = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  // Rotating pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // State registers; reset discards pending and in-flight events at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign out_multi_o = out_multi_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder (N=8). A behavioural model tracks pending events
// as a per-line flag array and is compared with the DUT on every falling
// edge; directed tests pin exact delivery sequences and cycle timing.
module tb_event_encoder;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_multi;
  logic             ovf_clr;
  logic             ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] got_q[$];

  event_encoder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_idx_o   (out_idx),
    .out_multi_o (out_multi),
    .ovf_clr_i   (ovf_clr),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend[N];
  bit m_valid;
  int m_idx;
  bit m_multi;
  bit m_ovf;
  int m_ptr;

  always @(posedge clk or negedge rst_n) begin
    int cnt;
    int pick;
    bit ld;
    bit lost;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_multi = 1'b0;
      m_ovf   = 1'b0;
      m_ptr   = 0;
    end else begin
      cnt  = 0;
      pick = -1;
      for (int k = 0; k < N; k++) if (m_pend[k]) cnt++;
      for (int o = 0; o < N; o++) begin
        if (pick < 0 && m_pend[(m_ptr + o) % N]) pick = (m_ptr + o) % N;
      end
      ld   = (cnt > 0) && (!m_valid || out_ready);
      lost = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (req[k] && m_pend[k] && !(ld && k == pick)) lost = 1'b1;
      end
      if (lost) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (ld && k == pick) m_pend[k] = 1'b0;
        if (req[k]) m_pend[k] = 1'b1;
      end
      if (ld) begin
        m_valid = 1'b1;
        m_idx   = pick;
        m_multi = (cnt > 1);
`ifdef EVENT_ENCODER_RR_EN
        m_ptr   = (pick + 1) % N;
`endif
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Record every accepted index on the edge where it transfers.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_idx);
  end

  // Compare the DUT with the model away from the active edge.
  always @(negedge clk) begin
    bit any_pend;
    any_pend = 1'b0;
    for (int k = 0; k < N; k++) if (m_pend[k]) any_pend = 1'b1;
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_idx", int'(out_idx), m_idx);
    chk("model_multi", int'(out_multi), int'(m_multi));
    chk("model_ovf", int'(ovf), int'(m_ovf));
    chk("model_busy", int'(busy), int'(any_pend || m_valid));
  end

  // ---------------- driver tasks ----------------
  // Drive inputs just after a falling edge and advance one full cycle.
  task automatic cyc(input logic [N-1:0] r, input logic rdy, input logic clr);
    req       = r;
    out_ready = rdy;
    ovf_clr   = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b1, 1'b0);
  endtask

  // Compare recorded deliveries with the expected queue, then clear both.
  task automatic check_deliveries(input string name);
    int n;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_item"}, int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_multi", int'(out_multi), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    // Single pulse on line 2: valid appears two edges after the pulse.
    cyc(8'b0000_0100, 1'b1, 1'b0);
    chk("t1_not_yet", int'(out_valid), 0);
    chk("t1_busy_pending", int'(busy), 1);
    cyc('0, 1'b1, 1'b0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_idx", int'(out_idx), 2);
    chk("t1_multi", int'(out_multi), 0);
    cyc('0, 1'b1, 1'b0);
    chk("t1_drop", int'(out_valid), 0);
    chk("t1_idle", int'(busy), 0);
    exp_q.push_back(3'd2);
    check_deliveries("t1");

    // Three events at once drain in index order at one per cycle.
    cyc(8'b0000_1011, 1'b1, 1'b0);
    cyc('0, 1'b1, 1'b0);
    chk("t2_idx0", int'(out_idx), 0);
    chk("t2_multi0", int'(out_multi), 1);
    cyc('0, 1'b1, 1'b0);
    chk("t2_idx1", int'(out_idx), 1);
    chk("t2_multi1", int'(out_multi), 1);
    cyc('0, 1'b1, 1'b0);
    chk("t2_idx3", int'(out_idx), 3);
    chk("t2_multi3", int'(out_multi), 0);
    idle(2);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd3);
    check_deliveries("t2");

    // Stall: index 0 held while line 3 waits in pending.
    cyc(8'b0000_0001, 1'b0, 1'b0);
    cyc(8'b0000_1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_idx", int'(out_idx), 0);
      cyc('0, 1'b0, 1'b0);
    end
    cyc('0, 1'b1, 1'b0);
    chk("t3_next_idx", int'(out_idx), 3);
    idle(2);
    exp_q.push_back(3'd0); exp_q.push_back(3'd3);
    check_deliveries("t3");

    // Overflow: second pulse on a still-pending line is merged and flagged.
    cyc(8'b0000_0001, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    cyc(8'b0000_0100, 1'b0, 1'b0);
    chk("t4_no_ovf", int'(ovf), 0);
    cyc(8'b0000_0100, 1'b0, 1'b0);
    chk("t4_ovf_set", int'(ovf), 1);
    idle(3);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2);
    check_deliveries("t4");
    cyc('0, 1'b1, 1'b1);
    chk("t4_ovf_clr", int'(ovf), 0);
    // Set wins over a simultaneous clear.
    cyc(8'b0000_0001, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    cyc(8'b0000_0010, 1'b0, 1'b0);
    cyc(8'b0000_0010, 1'b0, 1'b1);
    chk("t4_set_wins", int'(ovf), 1);
    cyc('0, 1'b0, 1'b1);
    chk("t4_clr_after", int'(ovf), 0);
    idle(3);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_deliveries("t4b");

    // Lines 0 and 4 held high: rotating priority alternates, fixed repeats 0.
    for (int i = 0; i < 6; i++) cyc(8'b0001_0001, 1'b1, 1'b0);
    idle(4);
`ifdef EVENT_ENCODER_RR_EN
    exp_q.push_back(3'd0); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
    exp_q.push_back(3'd4); exp_q.push_back(3'd0); exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(3'd0);
    exp_q.push_back(3'd4);
`endif
    check_deliveries("t5");
    cyc('0, 1'b1, 1'b1);

    // Reset mid-stream discards everything without waiting for a clock edge.
    cyc(8'hF0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("t6_pre_valid", int'(out_valid), 1);
    chk("t6_pre_idx", int'(out_idx), 4);
    chk("t6_pre_multi", int'(out_multi), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_idx", int'(out_idx), 0);
    chk("t6_async_multi", int'(out_multi), 0);
    chk("t6_async_ovf", int'(ovf), 0);
    chk("t6_async_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("t6_after_valid", int'(out_valid), 0);
    chk("t6_after_busy", int'(busy), 0);
    check_deliveries("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Parametrised N-to-log2(N) event encoder with state: captures single-cycle or level request pulses on N lines into a sticky pending register.
- Drains pending events one at a time, in priority order, as binary indices on a valid/ready output stream.
- Successor to the combinational 4:2 encoder. Bit k maps to index k, as before, but events are no longer lost when several arrive together or when the consumer stalls.
- Sits between interrupt/event sources and a single-issue consumer (controller or logger).

Parameters:
- N, 8, number of request lines. Must be >= 2. Need not be a power of two.
- IDX_W, $clog2(N), index width. Localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  N  event requests; a bit high in any cycle posts one event for that line
- out_ready_i  in  1  consumer accepts out_idx_o this cycle
- out_valid_o  out  1  out_idx_o holds an undelivered event
- out_idx_o  out  IDX_W  binary index of the delivered event
- out_multi_o  out  1  other events were still pending when this one was selected
- ovf_clr_i  in  1  synchronous clear of ovf_o
- ovf_o  out  1  sticky: an event merged into an already-pending bit
- busy_o  out  1  |pending OR out_valid_o (combinational)

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: pending=0, out_valid_o=0, out_idx_o=0, out_multi_o=0, ovf_o=0, rr_ptr=0. An assertion mid-operation discards all pending and in-flight events immediately, with no handshake.
- Pending update, every cycle: pending_next = (pending & ~sel_mask) | req_i.
  - sel_mask is the one-hot of the index loaded this cycle, or 0 if nothing loads.
  - If req_i hits the bit being loaded in the same cycle, that bit stays set: the new event is kept, not merged.
- Load condition: load = (|pending) && (!out_valid_o || out_ready_i).
- On load:
  - out_idx_o <= selected index.
  - out_valid_o <= 1.
  - out_multi_o <= popcount(pending) > 1.
- Valid drop: on out_valid_o && out_ready_i && !load, out_valid_o <= 0. out_idx_o and out_multi_o hold their last values.
- Output stability: while out_valid_o && !out_ready_i, out_idx_o and out_multi_o stay stable. New events only accumulate in pending.
- Selection (fixed priority): lowest set index of pending wins.
- Latency:
  - req_i pulse at edge t is in pending after t; out_valid_o rises after edge t+1 (2-cycle latency when idle).
  - Back-to-back delivery at 1 event/cycle while out_ready_i is held high.
- Overflow: ovf_o <= 1 when any bit of (req_i & pending & ~sel_mask) is set. ovf_clr_i clears it; set wins over a simultaneous clear.
- Full/empty: no depth limit. Each line holds at most one pending event, so a line never has two outstanding events (excess is counted by ovf_o only).
- X handling: out_idx_o must never be X after reset, even when idle.

Optional Feature:
- Macro: EVENT_ENCODER_RR_EN.
- Defined: rotating priority.
  - rr_ptr (IDX_W bits) marks the highest-priority line.
  - Search runs rr_ptr, rr_ptr+1, ... with wrap at N, not at 2^IDX_W.
  - On each load, rr_ptr <= (idx+1 == N) ? 0 : idx+1.
- Undefined: fixed lowest-index priority; rr_ptr does not exist.
- Port list is identical either way.

Decomposition:
- Package enc_pkg: clog2 helper function and a popcount-greater-than-one function.
- Sub-module prio_pick: purely combinational find-first-set over N bits with a base input, giving any-bit and index outputs. Base is tied to 0 when EVENT_ENCODER_RR_EN is undefined.
- event_encoder holds all state: pending, output register, rr_ptr, ovf.

Test Plan:
- N=4, out_ready_i=1: req_i=4'b0100 for 1 cycle -> out_valid_o high 2 cycles later, out_idx_o=2, out_multi_o=0. Then valid drops and busy_o=0.
- N=4, out_ready_i=1, fixed priority: req_i=4'b1011 for 1 cycle -> out_idx_o=0,1,3 on consecutive cycles, out_multi_o=1,1,0.
- Stall: out_ready_i=0, req_i=4'b0001 then 4'b1000 -> out_idx_o=0 held stable for 5 cycles. After release: 0 accepted, then 3.
- Overflow: pulse bit 2 twice while out_ready_i=0 and bit 2 pending -> ovf_o=1 and only one idx=2 delivered. ovf_clr_i pulse -> ovf_o=0.
- RR_EN, N=5, req_i held 5'b10001 -> out_idx_o alternates 0,4,0,4. Without RR_EN -> 0 every cycle.
- Reset mid-stream: rst_n low while pending=8'hF0 and out_valid_o=1 -> all outputs 0 asynchronously, before the next clk edge. No events delivered after release.
